// File: rtl/unidade_controle_jogo.sv
// Moore control unit for one ultimate tic-tac-toe game: sequences move entry,
// validation, board/state writes, serial wait and the player swap.
module unidade_controle_jogo (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       macro_vencida,
  input  logic       micro_jogada,
  input  logic       fim_jogo,
  input  logic       fimT,
  input  logic       fimS,
  output logic       zeraEdge,
  output logic       zeraR_micro,
  output logic       zeraR_macro,
  output logic       zeraFlipFlopT,
  output logic       zeraRAM,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraS,
  output logic       contaS,
  output logic       registraR_macro,
  output logic       registraR_micro,
  output logic       sinal_macro,
  output logic       sinal_valida_macro,
  output logic       we_board,
  output logic       we_board_state,
  output logic       troca_jogador,
  output logic       pronto,
  output logic [4:0] db_estado
);

  typedef enum logic [4:0] {
    INICIAL         = 5'h00,
    PREPARA         = 5'h01,
    ESPERA_MACRO    = 5'h02,
    REGISTRA_MACRO  = 5'h03,
    VALIDA_MACRO    = 5'h04,
    ESPERA_MICRO    = 5'h05,
    REGISTRA_MICRO  = 5'h06,
    VALIDA_MICRO    = 5'h07,
    ESCREVE_BOARD   = 5'h08,
    ESPERA_ATUALIZA = 5'h09,
    ESCREVE_STATE   = 5'h0A,
    VERIFICA_FIM    = 5'h0B,
    TRANSMITE       = 5'h0C,
    TROCA           = 5'h0D,
    AUTO_MACRO      = 5'h0E,
    FIM             = 5'h1F
  } estado_t;

  typedef struct packed {
    logic zera_edge;
    logic zera_r_micro;
    logic zera_r_macro;
    logic zera_ff_t;
    logic zera_ram;
    logic zera_t;
    logic conta_t;
    logic zera_s;
    logic conta_s;
    logic registra_macro;
    logic registra_micro;
    logic sinal_macro;
    logic sinal_valida_macro;
    logic we_board;
    logic we_board_state;
    logic troca_jogador;
    logic pronto;
  } saidas_t;

  estado_t estado;
  saidas_t saida;

  function automatic estado_t proximo(input estado_t e);
    estado_t n;
    n = e;
    case (e)
      INICIAL:         if (iniciar) n = PREPARA;
      PREPARA:         n = ESPERA_MACRO;
      ESPERA_MACRO:    if (tem_jogada) n = REGISTRA_MACRO;
      REGISTRA_MACRO:  n = VALIDA_MACRO;
      AUTO_MACRO:      n = VALIDA_MACRO;
      VALIDA_MACRO:    if (fimT) n = macro_vencida ? ESPERA_MACRO : ESPERA_MICRO;
      ESPERA_MICRO:    if (tem_jogada) n = REGISTRA_MICRO;
      REGISTRA_MICRO:  n = VALIDA_MICRO;
      VALIDA_MICRO:    if (fimT) n = micro_jogada ? ESPERA_MICRO : ESCREVE_BOARD;
      ESCREVE_BOARD:   n = ESPERA_ATUALIZA;
      ESPERA_ATUALIZA: if (fimT) n = ESCREVE_STATE;
      ESCREVE_STATE:   n = VERIFICA_FIM;
      VERIFICA_FIM:    n = fim_jogo ? FIM : TRANSMITE;
      TRANSMITE:       if (fimS) n = TROCA;
      TROCA:           n = AUTO_MACRO;
      FIM:             if (iniciar) n = PREPARA;
      default:         n = INICIAL;
    endcase
    return n;
  endfunction

  // Output decode of a state; registered against the state it describes.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARA: begin
        s.zera_edge    = 1'b1;
        s.zera_r_micro = 1'b1;
        s.zera_r_macro = 1'b1;
        s.zera_ff_t    = 1'b1;
        s.zera_ram     = 1'b1;
        s.zera_t       = 1'b1;
        s.zera_s       = 1'b1;
      end
      ESPERA_MACRO: begin
        s.sinal_macro        = 1'b1;
        s.sinal_valida_macro = 1'b1;
      end
      REGISTRA_MACRO: begin
        s.registra_macro     = 1'b1;
        s.sinal_macro        = 1'b1;
        s.zera_t             = 1'b1;
        s.sinal_valida_macro = 1'b1;
      end
      VALIDA_MACRO: begin
        s.conta_t            = 1'b1;
        s.sinal_valida_macro = 1'b1;
      end
      REGISTRA_MICRO: begin
        s.registra_micro = 1'b1;
        s.zera_t         = 1'b1;
      end
      VALIDA_MICRO:    s.conta_t = 1'b1;
      ESCREVE_BOARD: begin
        s.we_board = 1'b1;
        s.zera_t   = 1'b1;
      end
      ESPERA_ATUALIZA: s.conta_t = 1'b1;
      ESCREVE_STATE: begin
        s.we_board_state     = 1'b1;
        s.sinal_valida_macro = 1'b1;
      end
      VERIFICA_FIM:    s.zera_s = 1'b1;
      TRANSMITE:       s.conta_s = 1'b1;
      TROCA:           s.troca_jogador = 1'b1;
      // Forced macro is loaded from the micro register (sinal_macro = 0).
      AUTO_MACRO: begin
        s.registra_macro = 1'b1;
        s.zera_t         = 1'b1;
      end
      FIM:             s.pronto = 1'b1;
      default:         s = '0;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      saida  <= '0;
    end else begin
      estado <= proximo(estado);
      saida  <= decodifica(proximo(estado));
    end
  end

  assign db_estado          = estado;
  assign zeraEdge           = saida.zera_edge;
  assign zeraR_micro        = saida.zera_r_micro;
  assign zeraR_macro        = saida.zera_r_macro;
  assign zeraFlipFlopT      = saida.zera_ff_t;
  assign zeraRAM            = saida.zera_ram;
  assign zeraT              = saida.zera_t;
  assign contaT             = saida.conta_t;
  assign zeraS              = saida.zera_s;
  assign contaS             = saida.conta_s;
  assign registraR_macro    = saida.registra_macro;
  assign registraR_micro    = saida.registra_micro;
  assign sinal_macro        = saida.sinal_macro;
  assign sinal_valida_macro = saida.sinal_valida_macro;
  assign we_board           = saida.we_board;
  assign we_board_state     = saida.we_board_state;
  assign troca_jogador      = saida.troca_jogador;
  assign pronto             = saida.pronto;

endmodule
